// File: rtl/cache_control_if.sv
// Controller-side bundle: CPU request/response, datapath controls and physical memory handshake.
// master drives requests, tag status and pmem_resp; slave is the cache controller.
interface cache_control_if;
   logic mem_read;
   logic mem_write;
   logic mem_resp;
   logic hit;
   logic dirty;
   logic pmem_read;
   logic pmem_write;
   logic pmem_resp;
   logic load_data;
   logic load_tag;
   logic set_valid;
   logic set_dirty;
   logic clear_dirty;
   logic load_lru;
   logic data_sel;
   logic pmem_addr_sel;
   logic cache_hit;
   logic cache_miss;
   logic cache_writeback;

   modport slave (
      input  mem_read, mem_write, hit, dirty, pmem_resp,
      output mem_resp, pmem_read, pmem_write, load_data, load_tag, set_valid,
             set_dirty, clear_dirty, load_lru, data_sel, pmem_addr_sel,
             cache_hit, cache_miss, cache_writeback
   );

   modport master (
      output mem_read, mem_write, hit, dirty, pmem_resp,
      input  mem_resp, pmem_read, pmem_write, load_data, load_tag, set_valid,
             set_dirty, clear_dirty, load_lru, data_sel, pmem_addr_sel,
             cache_hit, cache_miss, cache_writeback
   );
endinterface

// File: rtl/cache_control.sv
// Write-back cache controller: zero-wait hits, miss -> optional writeback -> allocate -> replay in CHECK.
// Latency: hit same cycle, miss completes one cycle after final pmem_resp; pmem requests held until pmem_resp.
module cache_control (
   input  logic            clk,
   input  logic            rst,
   cache_control_if.slave  bus
);

   typedef enum logic [1:0] {CHECK, WRITEBACK, ALLOCATE} state_t;

   state_t state_q, state_d;
   logic   refill_q, refill_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= CHECK;
         refill_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         refill_q <= refill_d;
      end
   end

   always_comb begin
      state_d             = state_q;
      refill_d            = refill_q;
      bus.mem_resp        = 1'b0;
      bus.pmem_read       = 1'b0;
      bus.pmem_write      = 1'b0;
      bus.load_data       = 1'b0;
      bus.load_tag        = 1'b0;
      bus.set_valid       = 1'b0;
      bus.set_dirty       = 1'b0;
      bus.clear_dirty     = 1'b0;
      bus.load_lru        = 1'b0;
      bus.data_sel        = 1'b0;
      bus.pmem_addr_sel   = 1'b0;
      bus.cache_hit       = 1'b0;
      bus.cache_miss      = 1'b0;
      bus.cache_writeback = 1'b0;

      case (state_q)
         CHECK: begin
            refill_d = 1'b0;
            if (bus.mem_read || bus.mem_write) begin
               if (bus.hit) begin
                  bus.mem_resp  = 1'b1;
                  bus.load_lru  = 1'b1;
                  // The replay after a refill is the same access, so it must not count twice.
                  bus.cache_hit = !refill_q;
                  if (bus.mem_write) begin
                     bus.load_data = 1'b1;
                     bus.set_dirty = 1'b1;
                  end
               end else begin
                  bus.cache_miss = 1'b1;
                  if (bus.dirty) begin
                     bus.cache_writeback = 1'b1;
                     state_d             = WRITEBACK;
                  end else begin
                     state_d = ALLOCATE;
                  end
               end
            end
         end

         WRITEBACK: begin
            bus.pmem_write    = 1'b1;
            bus.pmem_addr_sel = 1'b1;
            if (bus.pmem_resp) begin
               state_d = ALLOCATE;
            end
         end

         ALLOCATE: begin
            bus.pmem_read = 1'b1;
            if (bus.pmem_resp) begin
               bus.load_data   = 1'b1;
               bus.data_sel    = 1'b1;
               bus.load_tag    = 1'b1;
               bus.set_valid   = 1'b1;
               bus.clear_dirty = 1'b1;
               refill_d        = 1'b1;
               state_d         = CHECK;
            end
         end

         default: begin
            state_d  = CHECK;
            refill_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: single-cycle vector table, multi-cycle miss/reset sequences, random scoreboard run.
module tb_cache_control;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cache_control_if bus ();

   cache_control dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   localparam logic [13:0] O_RESP  = 14'h2000;
   localparam logic [13:0] O_PRD   = 14'h1000;
   localparam logic [13:0] O_PWR   = 14'h0800;
   localparam logic [13:0] O_LDATA = 14'h0400;
   localparam logic [13:0] O_LTAG  = 14'h0200;
   localparam logic [13:0] O_SVAL  = 14'h0100;
   localparam logic [13:0] O_SDIRT = 14'h0080;
   localparam logic [13:0] O_CDIRT = 14'h0040;
   localparam logic [13:0] O_LLRU  = 14'h0020;
   localparam logic [13:0] O_DSEL  = 14'h0010;
   localparam logic [13:0] O_PSEL  = 14'h0008;
   localparam logic [13:0] O_HIT   = 14'h0004;
   localparam logic [13:0] O_MISS  = 14'h0002;
   localparam logic [13:0] O_WB    = 14'h0001;
   localparam logic [13:0] O_FILL  = O_PRD | O_LDATA | O_DSEL | O_LTAG | O_SVAL | O_CDIRT;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       name;
      logic        rd, wr, h, d, pr;
      logic [13:0] exp;
   } vec_t;

   typedef struct {
      logic h;
      logic wb;
      int   cycles;
   } sb_t;

   vec_t vt[9];
   sb_t  q[$];

   function automatic logic [13:0] outs();
      return {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.load_data, bus.load_tag,
              bus.set_valid, bus.set_dirty, bus.clear_dirty, bus.load_lru, bus.data_sel,
              bus.pmem_addr_sel, bus.cache_hit, bus.cache_miss, bus.cache_writeback};
   endfunction

   task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic h, input logic d, input logic pr);
      bus.mem_read  = rd;
      bus.mem_write = wr;
      bus.hit       = h;
      bus.dirty     = d;
      bus.pmem_resp = pr;
   endtask

   // Entered at posedge+1: drive, check at posedge+4, advance to the next posedge+1.
   task automatic cyc(input string nm, input logic rd, input logic wr, input logic h,
                      input logic d, input logic pr, input logic [13:0] exp);
      drive(rd, wr, h, d, pr);
      #3;
      check(nm, outs(), exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish before 500000");
      $fatal(1);
   end

   logic rd_r, h_r, d_r, hcur, prs, done;
   int   lw, lr, n, cnt, ah, am, aw;
   int   hit_tot, miss_tot, wb_tot, exp_wb_tot, overlap;
   sb_t  e;

   initial begin
      vt[0] = '{"idle",         0, 0, 0, 0, 0, 14'h0};
      vt[1] = '{"read_hit",     1, 0, 1, 0, 0, O_RESP | O_LLRU | O_HIT};
      vt[2] = '{"write_hit",    0, 1, 1, 1, 0, O_RESP | O_LLRU | O_HIT | O_LDATA | O_SDIRT};
      vt[3] = '{"rmiss_clean",  1, 0, 0, 0, 0, O_MISS};
      vt[4] = '{"rmiss_dirty",  1, 0, 0, 1, 0, O_MISS | O_WB};
      vt[5] = '{"wmiss_clean",  0, 1, 0, 0, 0, O_MISS};
      vt[6] = '{"wmiss_dirty",  0, 1, 0, 1, 0, O_MISS | O_WB};
      vt[7] = '{"idle_presp",   0, 0, 0, 0, 1, 14'h0};
      vt[8] = '{"idle_dirty",   0, 0, 1, 1, 0, 14'h0};

      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      #1;
      check("reset_async", outs(), 14'h0);
      @(posedge clk);
      #1;
      check("reset_held", outs(), 14'h0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         drive(vt[i].rd, vt[i].wr, vt[i].h, vt[i].d, vt[i].pr);
         #3;
         check(vt[i].name, outs(), vt[i].exp);
         drive(0, 0, 0, 0, 0);
         rst = 1'b1;
         #1;
         rst = 1'b0;
         @(posedge clk);
         #1;
      end

      // Clean read miss, fill responds on its 5th cycle.
      cyc("crm_c0", 1, 0, 0, 0, 0, O_MISS);
      for (int i = 1; i < 5; i++) cyc("crm_fill_wait", 1, 0, 0, 0, 0, O_PRD);
      cyc("crm_c5", 1, 0, 0, 0, 1, O_FILL);
      cyc("crm_c6", 1, 0, 1, 0, 0, O_RESP | O_LLRU);
      cyc("crm_c7", 0, 0, 0, 0, 0, 14'h0);

      // Dirty write miss, writeback and fill 3 cycles each.
      cyc("dwm_c0", 0, 1, 0, 1, 0, O_MISS | O_WB);
      cyc("dwm_c1", 0, 1, 0, 1, 0, O_PWR | O_PSEL);
      cyc("dwm_c2", 0, 1, 0, 1, 0, O_PWR | O_PSEL);
      cyc("dwm_c3", 0, 1, 0, 1, 1, O_PWR | O_PSEL);
      cyc("dwm_c4", 0, 1, 0, 0, 0, O_PRD);
      cyc("dwm_c5", 0, 1, 0, 0, 0, O_PRD);
      cyc("dwm_c6", 0, 1, 0, 0, 1, O_FILL);
      cyc("dwm_c7", 0, 1, 1, 0, 0, O_RESP | O_LDATA | O_SDIRT | O_LLRU);
      cyc("dwm_c8", 0, 0, 0, 0, 0, 14'h0);

      // Miss on the post-refill replay is a fresh miss; the final hit still counts nothing.
      cyc("flt_c0", 1, 0, 0, 0, 0, O_MISS);
      cyc("flt_c1", 1, 0, 0, 0, 1, O_FILL);
      cyc("flt_c2", 1, 0, 0, 0, 0, O_MISS);
      cyc("flt_c3", 1, 0, 0, 0, 1, O_FILL);
      cyc("flt_c4", 1, 0, 1, 0, 0, O_RESP | O_LLRU);

      // Request dropped during fill: fill completes, refill cleared by the idle cycle.
      cyc("drp_c0", 1, 0, 0, 0, 0, O_MISS);
      cyc("drp_c1", 0, 0, 0, 0, 0, O_PRD);
      cyc("drp_c2", 0, 0, 0, 0, 1, O_FILL);
      cyc("drp_c3", 0, 0, 0, 0, 0, 14'h0);
      cyc("drp_c4", 1, 0, 1, 0, 0, O_RESP | O_LLRU | O_HIT);

      // Reset in the middle of ALLOCATE.
      cyc("rstal_c0", 1, 0, 0, 0, 0, O_MISS);
      cyc("rstal_c1", 1, 0, 0, 0, 0, O_PRD);
      drive(1, 0, 0, 0, 0);
      #3;
      check("rstal_c2", outs(), O_PRD);
      rst = 1'b1;
      #1;
      check("rstal_prd_drop", {13'b0, bus.pmem_read}, 14'h0);
      drive(0, 0, 0, 0, 0);
      #1;
      check("rstal_idle_in_rst", outs(), 14'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc("rstal_after", 0, 0, 0, 0, 0, 14'h0);
      cyc("rstal_hit", 1, 0, 1, 0, 0, O_RESP | O_LLRU | O_HIT);

      // Random accesses against the scoreboard.
      hit_tot = 0; miss_tot = 0; wb_tot = 0; exp_wb_tot = 0; overlap = 0;
      for (int a = 0; a < 100; a++) begin
         rd_r = 1'($urandom_range(0, 1));
         h_r  = 1'($urandom_range(0, 1));
         d_r  = 1'($urandom_range(0, 1));
         lw   = $urandom_range(1, 3);
         lr   = $urandom_range(1, 3);
         e.h      = h_r;
         e.wb     = !h_r && d_r;
         e.cycles = h_r ? 1 : (d_r ? 2 + lw + lr : 2 + lr);
         q.push_back(e);
         if (e.wb) exp_wb_tot++;

         n = 0; cnt = 0; ah = 0; am = 0; aw = 0; done = 1'b0; hcur = h_r;
         while (!done && n < 40) begin
            prs = 1'b0;
            if (bus.pmem_write) begin
               cnt++;
               prs = (cnt == lw);
            end else if (bus.pmem_read) begin
               cnt++;
               prs = (cnt == lr);
            end
            drive(rd_r, !rd_r, hcur, d_r, prs);
            #3;
            ah += int'(bus.cache_hit);
            am += int'(bus.cache_miss);
            aw += int'(bus.cache_writeback);
            if (bus.pmem_read && bus.pmem_write) overlap++;
            n++;
            if (bus.mem_resp) done = 1'b1;
            if (prs) begin
               cnt = 0;
               if (bus.pmem_read) hcur = 1'b1;
            end
            @(posedge clk);
            #1;
         end
         drive(0, 0, 0, 0, 0);

         e = q.pop_front();
         if (!done) begin
            tests++;
            fails++;
            $display("FAIL rnd_timeout: access %0d got no mem_resp in %0d cycles, required one", a, n);
         end else begin
            check("rnd_pulses", {8'b0, 2'(ah), 2'(am), 2'(aw)},
                  {8'b0, 1'b0, e.h, 1'b0, !e.h, 1'b0, e.wb});
            check("rnd_latency", 14'(n), 14'(e.cycles));
         end
         hit_tot  += ah;
         miss_tot += am;
         wb_tot   += aw;
      end

      check("rnd_hit_miss_total", 14'(hit_tot + miss_tot), 14'd100);
      check("rnd_wb_total", 14'(wb_tot), 14'(exp_wb_tot));
      check("rnd_pmem_overlap", 14'(overlap), 14'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 The module SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mem_read / mem_write  input  1 each  CPU-side request, held until mem_resp; never both high.
REQ-005 mem_resp  output  1  request complete this cycle.
REQ-006 hit  input  1  datapath tag match on the current address.
REQ-007 dirty  input  1  LRU victim way is dirty.
REQ-008 pmem_read / pmem_write  output  1 each  physical memory line read/write, held until pmem_resp.
REQ-009 pmem_resp  input  1  physical memory transaction done.
REQ-010 load_data, load_tag, set_valid, set_dirty, clear_dirty, load_lru  output  1 each  datapath write enables.
REQ-011 data_sel  output  1  0 = CPU write data, 1 = pmem line.
REQ-012 pmem_addr_sel  output  1  0 = CPU address, 1 = victim tag/set (writeback).
REQ-013 cache_hit, cache_miss, cache_writeback  output  1 each  single-cycle event pulses to performance counters.

Function
REQ-014 States SHALL be CHECK, WRITEBACK, ALLOCATE; plus 1-bit register refill.
REQ-015 All outputs SHALL be combinational from state, refill and inputs; every output SHALL be 0 when no term below asserts it.
REQ-016 CHECK, no request: hold CHECK, all outputs 0.
REQ-017 CHECK, request and hit: mem_resp=1, load_lru=1 same cycle (zero-wait hit); on write also load_data=1, data_sel=0, set_dirty=1; stay CHECK; refill cleared.
REQ-018 cache_hit SHALL pulse for REQ-017 only when refill=0.
REQ-019 CHECK, request and miss: mem_resp=0, cache_miss=1; next state WRITEBACK if dirty=1 (cache_writeback=1 same cycle), else ALLOCATE.
REQ-020 WRITEBACK: pmem_write=1, pmem_addr_sel=1; on pmem_resp go ALLOCATE, else hold.
REQ-021 ALLOCATE: pmem_read=1, pmem_addr_sel=0; on pmem_resp assert load_data, data_sel=1, load_tag, set_valid, clear_dirty that cycle, set refill=1, go CHECK.
REQ-022 Post-refill CHECK SHALL complete via REQ-017 with no hit or miss pulse; mem_resp exactly one cycle after the final pmem_resp.
REQ-023 Each access SHALL produce exactly one of {cache_hit, cache_miss} pulse, each one cycle wide; cache_writeback at most once per access.
REQ-024 Request dropped during WRITEBACK/ALLOCATE: pmem transaction SHALL still complete; refill cleared on the next CHECK cycle with no request.
REQ-025 pmem_read and pmem_write SHALL never be high together; pmem_* SHALL stay stable until pmem_resp.
REQ-026 Miss in post-refill CHECK (datapath fault) SHALL be treated as a new miss per REQ-019.

Reset
REQ-027 rst=1 SHALL force state CHECK and refill=0 immediately, independent of clk.
REQ-028 During and after reset with no request, all outputs SHALL be 0; reset mid-WRITEBACK/ALLOCATE SHALL drop pmem_read/pmem_write in the same cycle.

Verification
REQ-029 Read hit: mem_read=1, hit=1 in CHECK -> mem_resp=1, load_lru=1, cache_hit=1 same cycle, no pmem activity.
REQ-030 Write hit: mem_write=1, hit=1 -> mem_resp, load_data, set_dirty, data_sel=0, cache_hit all 1 for one cycle.
REQ-031 Clean read miss, pmem_resp after 5 cycles: cache_miss pulse cycle 0; pmem_read cycles 1-5; load_tag/set_valid/clear_dirty at cycle 5; mem_resp cycle 6; cache_hit never asserted.
REQ-032 Dirty write miss, writeback and fill each 3 cycles: cache_miss and cache_writeback cycle 0; pmem_write+pmem_addr_sel cycles 1-3; pmem_read cycles 4-6; mem_resp with load_data/set_dirty cycle 7.
REQ-033 rst pulsed in ALLOCATE cycle 2 -> pmem_read 0 immediately; after release, idle CHECK, all outputs 0; next hit access counts one cache_hit.
REQ-034 100 random accesses against a scoreboard -> hit+miss pulse total = 100, writeback count = dirty-victim misses, no overlapping pmem_read/pmem_write.
